// File: rtl/fpga_pkg.sv
// Shared definitions for the out-channel reader: channel word width and controller states.
package fpga_pkg;

    localparam int MemoryElementWidth = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/out_channel_reader_if.sv
// Capture-side and read-side signals of the out-channel reader; master drives stimulus, slave is the reader.
interface out_channel_reader_if
#(
    parameter int DataWidth  = fpga_pkg::MemoryElementWidth,
    parameter int CountWidth = 16
);

    logic                  start;
    logic                  out_valid;
    logic [DataWidth-1:0]  out_data;
    logic                  program_finished;
    logic                  rd_valid;
    logic [DataWidth-1:0]  rd_data;
    logic                  rd_ready;
    logic                  overflow;
    logic [CountWidth-1:0] words_total;
    logic                  done;

    modport master (
        output start, out_valid, out_data, program_finished, rd_ready,
        input  rd_valid, rd_data, overflow, words_total, done
    );

    modport slave (
        input  start, out_valid, out_data, program_finished, rd_ready,
        output rd_valid, rd_data, overflow, words_total, done
    );

endinterface

// File: rtl/out_fifo.sv
// Circular word buffer; a write shows on rd_valid one cycle later, no bypass.
// Never overwrites: a write while full is taken only alongside a read; rd_data is 0 while empty.
module out_fifo
#(
    parameter int Width = 12,
    parameter int Depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [Width-1:0] rd_data,
    output logic             full
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             do_rd;
    logic             do_wr;

    assign do_rd = rd_en && (count != '0);
    assign do_wr = wr_en && ((count != CW'(Depth)) || do_rd);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Depth is a power of two, so the pointers wrap by plain overflow.
            if (do_wr) tail <= tail + AW'(1);
            if (do_rd) head <= head + AW'(1);
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr && !reset && !clear) mem[tail] <= wr_data;
    end

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[head] : '0;
    assign full     = (count == CW'(Depth));

endmodule

// File: rtl/out_channel_reader.sv
// Captures interpreter out-channel words into a buffer and drains them to a valid/ready consumer.
// Read latency 1 cycle after capture; when full, new words are dropped (sticky overflow) unless a read frees a slot.
module out_channel_reader
#(
    parameter int MemoryElementWidth = fpga_pkg::MemoryElementWidth,
    parameter int NOut               = 4,
    parameter int CountWidth         = 16
) (
    input logic                 clock,
    input logic                 reset,
    out_channel_reader_if.slave bus
);

    import fpga_pkg::*;

    localparam logic [CountWidth-1:0] TotalMax = '1;

    state_t                        state;
    state_t                        state_nxt;
    logic                          fifo_valid;
    logic                          fifo_full;
    logic [MemoryElementWidth-1:0] fifo_data;
    logic                          rd_fire;
    logic                          wr_req;
    logic                          wr_accept;
    logic                          wr_drop;
    logic                          overflow_q;
    logic [CountWidth-1:0]         total_q;

    assign rd_fire   = fifo_valid && bus.rd_ready;
    // start wipes the buffer this cycle, so a coincident word is not captured.
    assign wr_req    = (state == RUN) && bus.out_valid && !bus.start;
    assign wr_accept = wr_req && (!fifo_full || rd_fire);
    assign wr_drop   = wr_req && fifo_full && !rd_fire;

    out_fifo #(
        .Width (MemoryElementWidth),
        .Depth (NOut)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (bus.start),
        .wr_en    (wr_accept),
        .wr_data  (bus.out_data),
        .rd_en    (rd_fire),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_data),
        .full     (fifo_full)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (bus.program_finished) state_nxt = DRAIN;
                DRAIN:   if (!fifo_valid) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bus.start) begin
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else begin
            if (wr_drop) overflow_q <= 1'b1;
            if (wr_accept && (total_q != TotalMax)) total_q <= total_q + CountWidth'(1);
        end
    end

    assign bus.rd_valid    = fifo_valid;
    assign bus.rd_data     = fifo_data;
    assign bus.overflow    = overflow_q;
    assign bus.words_total = total_q;
    assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_out_channel_reader.sv
// Randomized and directed bench for out_channel_reader against a queue-based reference model.
module tb_out_channel_reader;

    import fpga_pkg::*;

    localparam int W    = 12;
    localparam int NOUT = 4;
    localparam int CW   = 5;
    localparam int TMAX = 31;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    out_channel_reader_if #(.DataWidth(W), .CountWidth(CW)) bus ();

    out_channel_reader #(
        .MemoryElementWidth (W),
        .NOut               (NOUT),
        .CountWidth         (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: an ordered list of buffered words plus the control state.
    logic [W-1:0] q[$];
    int           m_total;
    bit           m_ovf;
    state_t       m_st;

    function automatic void model_edge();
        int sz;
        bit rd;
        bit acc;
        sz = q.size();
        if (reset) begin
            q.delete(); m_ovf = 0; m_total = 0; m_st = IDLE;
            return;
        end
        if (bus.start) begin
            q.delete(); m_ovf = 0; m_total = 0; m_st = RUN;
            return;
        end
        rd  = (sz > 0) && bus.rd_ready;
        acc = 0;
        if (m_st == RUN && bus.out_valid) begin
            if (sz < NOUT || rd) acc = 1;
            else m_ovf = 1;
        end
        if (rd) void'(q.pop_front());
        if (acc) begin
            q.push_back(bus.out_data);
            if (m_total < TMAX) m_total++;
        end
        if (m_st == RUN && bus.program_finished) m_st = DRAIN;
        else if (m_st == DRAIN && sz == 0) m_st = DONE;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wr(input logic [W-1:0] d);
        bus.out_valid = 1'b1;
        bus.out_data  = d;
        tick();
        bus.out_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b expected 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 12'h000) begin errors++; $display("FAIL reset_rd_data got %h expected 000", bus.rd_data); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", bus.overflow); end
        checks++; if (bus.words_total !== 5'd0) begin errors++; $display("FAIL reset_words_total got %0d expected 0", bus.words_total); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d expected IDLE", dut.state); end
        wr(12'h005);
        wr(12'h006);
        checks++; if (bus.rd_valid !== 1'b0 || bus.words_total !== 5'd0 || bus.overflow !== 1'b0)
            begin errors++; $display("FAIL idle_ignored got valid=%b total=%0d ovf=%b expected 0/0/0", bus.rd_valid, bus.words_total, bus.overflow); end
    endtask

    task automatic test_single_write();
        do_start();
        bus.out_valid = 1'b1;
        bus.out_data  = 12'h002;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b expected 0", bus.rd_valid); end
        tick();
        bus.out_valid = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 12'h002)
            begin errors++; $display("FAIL single_word got valid=%b data=%h expected 1/002", bus.rd_valid, bus.rd_data); end
        checks++; if (bus.words_total !== 5'd1) begin errors++; $display("FAIL single_total got %0d expected 1", bus.words_total); end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %b expected 0", bus.rd_valid); end
    endtask

    task automatic test_overflow();
        do_start();
        for (int v = 1; v <= 4; v++) wr(W'(v));
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b expected 0", bus.overflow); end
        wr(12'h005);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b expected 1", bus.overflow); end
        checks++; if (bus.words_total !== 5'd4) begin errors++; $display("FAIL drop_total got %0d expected 4", bus.words_total); end
        bus.rd_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== W'(v))
                begin errors++; $display("FAIL drop_drain[%0d] got valid=%b data=%h expected 1/%h", v, bus.rd_valid, bus.rd_data, W'(v)); end
            tick();
        end
        bus.rd_ready = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL drop_empty got %b expected 0", bus.rd_valid); end
    endtask

    task automatic test_full_rw();
        logic [W-1:0] exp_seq [4];
        exp_seq = '{12'h002, 12'h003, 12'h004, 12'h009};
        do_start();
        for (int v = 1; v <= 4; v++) wr(W'(v));
        bus.rd_ready  = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = 12'h009;
        tick();
        bus.out_valid = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_rw_ovf got %b expected 0", bus.overflow); end
        checks++; if (bus.words_total !== 5'd5) begin errors++; $display("FAIL full_rw_total got %0d expected 5", bus.words_total); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_seq[k])
                begin errors++; $display("FAIL full_rw_drain[%0d] got valid=%b data=%h expected 1/%h", k, bus.rd_valid, bus.rd_data, exp_seq[k]); end
            tick();
        end
        bus.rd_ready = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL full_rw_empty got %b expected 0", bus.rd_valid); end
    endtask

    task automatic test_back_to_back_wrap();
        do_start();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.out_valid = 1'b1;
            bus.out_data  = W'(100 + i);
            tick();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== W'(100 + i))
                begin errors++; $display("FAIL wrap[%0d] got valid=%b data=%h expected 1/%h", i, bus.rd_valid, bus.rd_data, W'(100 + i)); end
        end
        bus.out_valid = 1'b0;
        tick();
        bus.rd_ready = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b expected 0", bus.rd_valid); end
        checks++; if (bus.words_total !== 5'd6) begin errors++; $display("FAIL wrap_total got %0d expected 6", bus.words_total); end
    endtask

    task automatic test_drain_done();
        do_start();
        wr(12'h011); wr(12'h012); wr(12'h013);
        bus.program_finished = 1'b1;
        tick();
        checks++; if (dut.state !== DRAIN) begin errors++; $display("FAIL drain_state got %0d expected DRAIN", dut.state); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.done !== 1'b0 || bus.rd_valid !== 1'b1 || bus.rd_data !== 12'h011)
                begin errors++; $display("FAIL drain_hold[%0d] got done=%b valid=%b data=%h expected 0/1/011", k, bus.done, bus.rd_valid, bus.rd_data); end
        end
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.rd_data !== W'(12'h011 + k))
                begin errors++; $display("FAIL drain_read[%0d] got %h expected %h", k, bus.rd_data, W'(12'h011 + k)); end
            tick();
        end
        checks++; if (bus.rd_valid !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL drain_last got valid=%b done=%b expected 0/0", bus.rd_valid, bus.done); end
        tick();
        checks++; if (bus.done !== 1'b1 || dut.state !== DONE)
            begin errors++; $display("FAIL done_rise got done=%b state=%0d expected 1/DONE", bus.done, dut.state); end
        bus.rd_ready  = 1'b0;
        bus.out_valid = 1'b1;
        bus.out_data  = 12'h0aa;
        tick();
        tick();
        bus.out_valid = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0 || bus.words_total !== 5'd3)
            begin errors++; $display("FAIL done_ignore got done=%b ovf=%b valid=%b total=%0d expected 1/0/0/3", bus.done, bus.overflow, bus.rd_valid, bus.words_total); end
        bus.program_finished = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        do_start();
        wr(12'h021); wr(12'h022);
        bus.program_finished = 1'b1;
        tick();
        checks++; if (dut.state !== DRAIN || bus.rd_valid !== 1'b1)
            begin errors++; $display("FAIL mid_drain_pre got state=%0d valid=%b expected DRAIN/1", dut.state, bus.rd_valid); end
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.program_finished = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0 || bus.done !== 1'b0 || bus.rd_data !== 12'h000 || dut.state !== IDLE)
            begin errors++; $display("FAIL mid_drain_reset got valid=%b done=%b data=%h state=%0d expected 0/0/000/IDLE", bus.rd_valid, bus.done, bus.rd_data, dut.state); end
        do_start();
        wr(12'h007);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 12'h007 || bus.words_total !== 5'd1)
            begin errors++; $display("FAIL recapture got valid=%b data=%h total=%0d expected 1/007/1", bus.rd_valid, bus.rd_data, bus.words_total); end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_start();
        bus.rd_ready  = 1'b1;
        bus.out_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.out_data = W'(i);
            tick();
        end
        bus.out_valid = 1'b0;
        tick();
        bus.rd_ready = 1'b0;
        checks++; if (bus.words_total !== 5'd31) begin errors++; $display("FAIL saturate got %0d expected 31", bus.words_total); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL saturate_ovf got %b expected 0", bus.overflow); end
    endtask

    task automatic test_random();
        do_start();
        for (int cyc = 0; cyc < 1200; cyc++) begin
            bus.start            = ((cyc % 200) == 199);
            bus.program_finished = ((cyc % 200) > 140);
            bus.out_valid        = ($urandom_range(0, 99) < 60);
            bus.out_data         = W'($urandom);
            bus.rd_ready         = ($urandom_range(0, 99) < 45);
            tick();
            checks++; if (bus.rd_valid !== (q.size() > 0))
                begin errors++; $display("FAIL rand_valid cyc %0d got %b expected %b", cyc, bus.rd_valid, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (bus.rd_data !== q[0])
                    begin errors++; $display("FAIL rand_data cyc %0d got %h expected %h", cyc, bus.rd_data, q[0]); end
            end
            checks++; if (bus.overflow !== m_ovf)
                begin errors++; $display("FAIL rand_overflow cyc %0d got %b expected %b", cyc, bus.overflow, m_ovf); end
            checks++; if (bus.words_total !== CW'(m_total))
                begin errors++; $display("FAIL rand_total cyc %0d got %0d expected %0d", cyc, bus.words_total, m_total); end
            checks++; if (bus.done !== (m_st == DONE))
                begin errors++; $display("FAIL rand_done cyc %0d got %b expected %b", cyc, bus.done, m_st == DONE); end
        end
        bus.start = 1'b0; bus.program_finished = 1'b0; bus.out_valid = 1'b0; bus.rd_ready = 1'b0;
        do_start();
        checks++; if (bus.overflow !== 1'b0 || bus.words_total !== 5'd0 || bus.rd_valid !== 1'b0 || dut.state !== RUN)
            begin errors++; $display("FAIL start_clear got ovf=%b total=%0d valid=%b state=%0d expected 0/0/0/RUN", bus.overflow, bus.words_total, bus.rd_valid, dut.state); end
    endtask

    initial begin
        reset                = 1'b1;
        bus.start            = 1'b0;
        bus.out_valid        = 1'b0;
        bus.out_data         = '0;
        bus.program_finished = 1'b0;
        bus.rd_ready         = 1'b0;
        test_reset();
        test_single_write();
        test_overflow();
        test_full_rw();
        test_back_to_back_wrap();
        test_drain_done();
        test_reset_mid_drain();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
